payload_seq_ctrl: RTL and testbench
===================================

PAYLOAD_SEQ_CTRL -- requirements
Module: payload_seq_ctrl

Interface
REQ-001 Parameter FRAME_BITS, default 8640, SHALL be the encoded payload bits per frame.
REQ-002 Parameter PAD_BITS, default 960, SHALL be the padding bits the padding unit appends per frame.
REQ-003 Parameter SYM_BITS, default 1920, SHALL be the bits per payload symbol; (FRAME_BITS+PAD_BITS)/SYM_BITS = 5.
REQ-004 Parameter TIMEOUT, default 4095, SHALL be the maximum idle cycles tolerated in DRAIN.
REQ-005 clk  in  1  working clock; single clock domain.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  one-cycle frame start request; ignored unless IDLE.
REQ-008 enc_bit / enc_vld  in  1 / 1  encoded payload bit stream and its valid.
REQ-009 enc_rdy  out  1  SHALL be high exactly while state is LOAD.
REQ-010 ppu_di / ppu_di_vld  out  1 / 1  registered bit and valid driven to the padding unit.
REQ-011 ppu_do_vld  in  1  padding unit output-valid, observed only.
REQ-012 ppu_done_rst  out  1  one-cycle clear pulse to the padding unit.
REQ-013 busy  out  1  SHALL be high whenever state is not IDLE.
REQ-014 sym_strb / sym_idx  out  1 / 3  pulse on last bit of each output symbol; index 0..4 of that symbol.
REQ-015 frame_done  out  1  one-cycle pulse at frame completion.
REQ-016 err_underrun / err_timeout  out  1 / 1  sticky error flags, cleared only by start or reset.

Function
REQ-017 States SHALL be IDLE, LOAD, DRAIN, FLUSH, DONE; encoding 3 bits.
REQ-018 IDLE->LOAD on start; start also clears in_cnt, out_cnt, sym_idx and both error flags.
REQ-019 In LOAD each cycle with enc_vld high SHALL register ppu_di<=enc_bit, ppu_di_vld<=1 next cycle (latency 1) and increment 14-bit in_cnt.
REQ-020 LOAD->DRAIN in the cycle the FRAME_BITS-th bit is accepted; enc_rdy drops the following cycle.
REQ-021 enc_vld low in LOAD after first bit accepted SHALL set err_underrun and go to FLUSH (padding unit requires contiguous valid); enc_vld low before first bit is a legal wait.
REQ-022 In DRAIN each ppu_do_vld cycle SHALL increment 14-bit out_cnt and 11-bit sym_cnt; sym_cnt==SYM_BITS-1 SHALL pulse sym_strb with current sym_idx, zero sym_cnt, and increment sym_idx.
REQ-023 DRAIN->FLUSH when out_cnt reaches FRAME_BITS+PAD_BITS (9600) and ppu_do_vld is low.
REQ-024 A 12-bit idle counter SHALL reset on any ppu_do_vld and increment otherwise in DRAIN; reaching TIMEOUT SHALL set err_timeout and go to FLUSH.
REQ-025 ppu_do_vld beyond 9600 bits SHALL be ignored (no further sym_strb, counters saturate).
REQ-026 FLUSH SHALL assert ppu_done_rst for exactly one cycle, then go to DONE.
REQ-027 DONE SHALL pulse frame_done for one cycle (also on error abort) and return to IDLE.
REQ-028 start while busy SHALL be ignored with no state or flag change.

Reset
REQ-029 rst_n low at a clock edge SHALL force IDLE and zero every output, counter and flag, including mid-LOAD or mid-DRAIN.
REQ-030 Reset SHALL NOT pulse ppu_done_rst; the padding unit is reset by its own reset.

Structure
REQ-031 State encoding and FRAME_BITS/PAD_BITS/SYM_BITS defaults SHALL live in the shared global define file.
REQ-032 The output symbol counter (sym_cnt, sym_idx, sym_strb) SHALL be a sub-module named sym_counter.

Verification
REQ-033 start, then 8640 contiguous enc_vld bits -> ppu_di_vld high 8640 cycles starting 1 cycle after first accept, enc_rdy low after bit 8640.
REQ-034 Model 9600 ppu_do_vld bits -> sym_strb at bits 1920,3840,5760,7680,9600 with sym_idx 0..4; single ppu_done_rst; frame_done one cycle later.
REQ-035 enc_vld gap at bit 4000 -> err_underrun=1, ppu_done_rst pulse, frame_done, IDLE; flags clear on next start.
REQ-036 ppu_do_vld stops after 5000 bits -> err_timeout set exactly 4095 idle cycles later, then FLUSH/DONE.
REQ-037 rst_n low mid-DRAIN -> all outputs 0 next cycle, state IDLE, no ppu_done_rst.
REQ-038 start pulsed during LOAD and DRAIN -> ignored; frame completes normally with counts unchanged.

Source files
------------

// File: rtl/payload_seq_ctrl_pkg.sv
// Shared definitions for the payload sequencing controller: frame geometry
// defaults, counter widths and the controller state encoding.
// Pure declarations; no logic, latency or flow control of its own.
package payload_seq_ctrl_pkg;

  // Default frame geometry: (FRAME_BITS + PAD_BITS) / SYM_BITS = 5 symbols.
  localparam int DEF_FRAME_BITS = 8640;
  localparam int DEF_PAD_BITS   = 960;
  localparam int DEF_SYM_BITS   = 1920;
  localparam int DEF_TIMEOUT    = 4095;

  // Counter widths sized for the default geometry.
  localparam int CNT_W     = 14;  // in_cnt / out_cnt, covers 9600
  localparam int SYM_CNT_W = 11;  // bit position inside a symbol, covers 1919
  localparam int IDLE_W    = 12;  // DRAIN idle counter, covers 4095
  localparam int SYM_IDX_W = 3;   // symbol index 0..4

  // Controller states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Increment that sticks at lim instead of running past it.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/payload_seq_ctrl_if.sv
// Bundle of frame-control, encoder and padding-unit signals of the controller.
// Wires only; timing is set by the controller behind the slave modport.
// enc_vld/enc_rdy is the only handshake; the padding unit side is observe-only.
interface payload_seq_ctrl_if;
  import payload_seq_ctrl_pkg::*;

  logic                 start;
  logic                 enc_bit;
  logic                 enc_vld;
  logic                 enc_rdy;
  logic                 ppu_di;
  logic                 ppu_di_vld;
  logic                 ppu_do_vld;
  logic                 ppu_done_rst;
  logic                 busy;
  logic                 sym_strb;
  logic [SYM_IDX_W-1:0] sym_idx;
  logic                 frame_done;
  logic                 err_underrun;
  logic                 err_timeout;

  // Master: the surroundings (encoder, padding unit, frame scheduler).
  modport master (
    output start, enc_bit, enc_vld, ppu_do_vld,
    input  enc_rdy, ppu_di, ppu_di_vld, ppu_done_rst, busy,
           sym_strb, sym_idx, frame_done, err_underrun, err_timeout
  );

  // Slave: the controller itself.
  modport slave (
    input  start, enc_bit, enc_vld, ppu_do_vld,
    output enc_rdy, ppu_di, ppu_di_vld, ppu_done_rst, busy,
           sym_strb, sym_idx, frame_done, err_underrun, err_timeout
  );

endinterface

// File: rtl/sym_counter.sv
// Splits the padding-unit output stream into symbols and flags each symbol end.
// Strobe and index are registered: they appear one cycle after the last bit.
// No backpressure; counts every cycle cnt_en_i is high, clr_i has priority.
module sym_counter
  import payload_seq_ctrl_pkg::*;
#(
  parameter int SYM_BITS = DEF_SYM_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 cnt_en_i,
  output logic                 sym_strb_o,
  output logic [SYM_IDX_W-1:0] sym_idx_o
);

  localparam logic [SYM_CNT_W-1:0] SYM_LAST = SYM_CNT_W'(SYM_BITS - 1);

  logic [SYM_CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [SYM_IDX_W-1:0] idx_q, idx_d;          // index of the symbol in progress
  logic [SYM_IDX_W-1:0] sym_idx_q, sym_idx_d;  // index of the last completed symbol
  logic                 sym_strb_q, sym_strb_d;

  // Next state: advance the bit position, wrap and strobe at the symbol end.
  always_comb begin
    sym_cnt_d  = sym_cnt_q;
    idx_d      = idx_q;
    sym_idx_d  = sym_idx_q;
    sym_strb_d = 1'b0;
    if (clr_i) begin
      sym_cnt_d = '0;
      idx_d     = '0;
      sym_idx_d = '0;
    end else if (cnt_en_i) begin
      if (sym_cnt_q == SYM_LAST) begin
        sym_cnt_d  = '0;
        sym_strb_d = 1'b1;
        sym_idx_d  = idx_q;
        idx_d      = idx_q + SYM_IDX_W'(1);
      end else begin
        sym_cnt_d = sym_cnt_q + SYM_CNT_W'(1);
      end
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sym_cnt_q  <= '0;
      idx_q      <= '0;
      sym_idx_q  <= '0;
      sym_strb_q <= 1'b0;
    end else begin
      sym_cnt_q  <= sym_cnt_d;
      idx_q      <= idx_d;
      sym_idx_q  <= sym_idx_d;
      sym_strb_q <= sym_strb_d;
    end
  end

  assign sym_strb_o = sym_strb_q;
  assign sym_idx_o  = sym_idx_q;

endmodule

// File: rtl/payload_seq_ctrl.sv
// Sequences one frame: feeds encoded bits to the padding unit, counts its output, then flushes.
// ppu_di/ppu_di_vld follow an accepted encoder bit by 1 cycle; all outputs are registered.
// enc_rdy is high only in LOAD; the padding unit output cannot be stalled, only observed.
module payload_seq_ctrl
  import payload_seq_ctrl_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int PAD_BITS   = DEF_PAD_BITS,
  parameter int SYM_BITS   = DEF_SYM_BITS,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               rst_n,
  payload_seq_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0]  IN_LAST   = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0]  OUT_TOTAL = CNT_W'(FRAME_BITS + PAD_BITS);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  state_e               state_q;
  logic [CNT_W-1:0]     in_cnt_q;
  logic [CNT_W-1:0]     out_cnt_q;
  logic [IDLE_W-1:0]    idle_cnt_q;
  logic                 enc_rdy_q;
  logic                 busy_q;
  logic                 ppu_di_q;
  logic                 ppu_di_vld_q;
  logic                 ppu_done_rst_q;
  logic                 frame_done_q;
  logic                 err_underrun_q;
  logic                 err_timeout_q;

  logic                 start_acc;
  logic                 out_acc;
  logic                 sym_strb;
  logic [SYM_IDX_W-1:0] sym_idx;

  // A start only counts in IDLE; output bits only count in DRAIN and up to the frame total.
  assign start_acc = (state_q == ST_IDLE) && bus.start;
  assign out_acc   = (state_q == ST_DRAIN) && bus.ppu_do_vld && (out_cnt_q < OUT_TOTAL);

  // Frame FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
      idle_cnt_q     <= '0;
      enc_rdy_q      <= 1'b0;
      busy_q         <= 1'b0;
      ppu_di_q       <= 1'b0;
      ppu_di_vld_q   <= 1'b0;
      ppu_done_rst_q <= 1'b0;
      frame_done_q   <= 1'b0;
      err_underrun_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      // Pulses default low; they are raised only on the transition that owns them.
      ppu_done_rst_q <= 1'b0;
      frame_done_q   <= 1'b0;
      ppu_di_vld_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q        <= ST_LOAD;
            enc_rdy_q      <= 1'b1;
            busy_q         <= 1'b1;
            in_cnt_q       <= '0;
            out_cnt_q      <= '0;
            idle_cnt_q     <= '0;
            err_underrun_q <= 1'b0;
            err_timeout_q  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (bus.enc_vld) begin
            ppu_di_q     <= bus.enc_bit;
            ppu_di_vld_q <= 1'b1;
            in_cnt_q     <= in_cnt_q + CNT_W'(1);
            if (in_cnt_q == IN_LAST) begin
              state_q   <= ST_DRAIN;
              enc_rdy_q <= 1'b0;
            end
          end else if (in_cnt_q != '0) begin
            // The padding unit needs a gap-free input once the frame has begun.
            err_underrun_q <= 1'b1;
            enc_rdy_q      <= 1'b0;
            state_q        <= ST_FLUSH;
            ppu_done_rst_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (bus.ppu_do_vld) begin
            idle_cnt_q <= '0;
            out_cnt_q  <= sat_inc(out_cnt_q, OUT_TOTAL);
          end else if (out_cnt_q == OUT_TOTAL) begin
            state_q        <= ST_FLUSH;
            ppu_done_rst_q <= 1'b1;
          end else if (idle_cnt_q == IDLE_LAST) begin
            idle_cnt_q     <= idle_cnt_q + IDLE_W'(1);
            err_timeout_q  <= 1'b1;
            state_q        <= ST_FLUSH;
            ppu_done_rst_q <= 1'b1;
          end else begin
            idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
          end
        end
        ST_FLUSH: begin
          state_q      <= ST_DONE;
          frame_done_q <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          enc_rdy_q <= 1'b0;
        end
      endcase
    end
  end

  sym_counter #(
    .SYM_BITS (SYM_BITS)
  ) u_sym_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (start_acc),
    .cnt_en_i   (out_acc),
    .sym_strb_o (sym_strb),
    .sym_idx_o  (sym_idx)
  );

  assign bus.enc_rdy      = enc_rdy_q;
  assign bus.busy         = busy_q;
  assign bus.ppu_di       = ppu_di_q;
  assign bus.ppu_di_vld   = ppu_di_vld_q;
  assign bus.ppu_done_rst = ppu_done_rst_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.err_underrun = err_underrun_q;
  assign bus.err_timeout  = err_timeout_q;
  assign bus.sym_strb     = sym_strb;
  assign bus.sym_idx      = sym_idx;

endmodule

// File: tb/tb_payload_seq_ctrl.sv
// Directed bench for payload_seq_ctrl with scoreboards for padding-unit input bits and symbol indices.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Exercises normal frame, ignored starts, underrun, timeout and reset mid-DRAIN.
module tb_payload_seq_ctrl;
  import payload_seq_ctrl_pkg::*;

  localparam int FB    = 8640;
  localparam int PB    = 960;
  localparam int SB    = 1920;
  localparam int TO    = 4095;
  localparam int TOTAL = FB + PB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  payload_seq_ctrl_if bus ();

  payload_seq_ctrl #(
    .FRAME_BITS (FB),
    .PAD_BITS   (PB),
    .SYM_BITS   (SB),
    .TIMEOUT    (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  bit di_q[$];   // expected ppu_di bits, pushed on accept
  int idx_q[$];  // expected sym_idx values, pushed when a symbol's last bit is driven

  int cyc            = 0;
  int di_vld_cnt     = 0;
  int done_rst_cnt   = 0;
  int frame_done_cnt = 0;
  int strb_cnt       = 0;
  int dr_cyc         = 0;
  int fd_cyc         = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.enc_rdy, bus.busy, bus.ppu_di, bus.ppu_di_vld, bus.ppu_done_rst,
                bus.sym_strb, bus.sym_idx, bus.frame_done, bus.err_underrun, bus.err_timeout});
  endfunction

  // Output monitor: drains the scoreboards and counts pulses.
  always @(negedge clk) begin
    cyc++;
    if (bus.ppu_di_vld === 1'b1) begin
      di_vld_cnt++;
      chk("di_sb_nonempty", 32'(di_q.size() != 0), 1);
      if (di_q.size() != 0) chk("ppu_di", 32'(bus.ppu_di), 32'(di_q.pop_front()));
    end
    if (bus.sym_strb === 1'b1) begin
      strb_cnt++;
      chk("sym_sb_nonempty", 32'(idx_q.size() != 0), 1);
      if (idx_q.size() != 0) chk("sym_idx", 32'(bus.sym_idx), 32'(idx_q.pop_front()));
    end
    if (bus.ppu_done_rst === 1'b1) begin
      done_rst_cnt++;
      dr_cyc = cyc;
    end
    if (bus.frame_done === 1'b1) begin
      frame_done_cnt++;
      fd_cyc = cyc;
    end
  end

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // n contiguous encoder bits; optional start pulse at bit start_at.
  task automatic load_bits(input int n, input int start_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) chk("di_vld_before_first", 32'(bus.ppu_di_vld), 0);
      if (i == 1) chk("di_vld_latency1", 32'(bus.ppu_di_vld), 1);
      bus.start   = (i == start_at);
      bus.enc_vld = 1'b1;
      bus.enc_bit = 1'($urandom);
      if (bus.enc_rdy === 1'b1) di_q.push_back(bus.enc_bit);
    end
    @(negedge clk);
    bus.enc_vld = 1'b0;
    bus.start   = 1'b0;
  endtask

  // n padding-unit output bits (plus extra beyond the frame), with short gaps.
  task automatic drain_bits(input int n, input int extra, input int start_at);
    int k = 0;
    int c = 0;
    bit exp_strb = 1'b0;
    while (k < n + extra && c < 4 * TOTAL) begin
      @(negedge clk);
      chk("sym_strb", 32'(bus.sym_strb), 32'(exp_strb));
      bus.start      = (c == start_at);
      bus.ppu_do_vld = ((c % 700) != 350);
      exp_strb       = 1'b0;
      if (bus.ppu_do_vld) begin
        k++;
        exp_strb = (k <= TOTAL) && (k % SB == 0);
        if (exp_strb) idx_q.push_back(k / SB - 1);
      end
      c++;
    end
    @(negedge clk);
    chk("sym_strb", 32'(bus.sym_strb), 32'(exp_strb));
    bus.ppu_do_vld = 1'b0;
    bus.start      = 1'b0;
  endtask

  initial begin
    int b_di, b_dr, b_fd, b_strb;
    bus.start      = 1'b0;
    bus.enc_bit    = 1'b0;
    bus.enc_vld    = 1'b0;
    bus.ppu_do_vld = 1'b0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);

    // Normal frame, with start pulses during LOAD and DRAIN that must be ignored.
    do_start();
    chk("a_enc_rdy", 32'(bus.enc_rdy), 1);
    chk("a_busy", 32'(bus.busy), 1);
    repeat (3) @(negedge clk);
    chk("a_wait_rdy", 32'(bus.enc_rdy), 1);
    chk("a_wait_no_err", 32'(bus.err_underrun), 0);
    b_di = di_vld_cnt; b_dr = done_rst_cnt; b_fd = frame_done_cnt; b_strb = strb_cnt;
    load_bits(FB, 100);
    chk("a_rdy_drop", 32'(bus.enc_rdy), 0);
    chk("a_busy_drain", 32'(bus.busy), 1);
    drain_bits(TOTAL, 3, 2000);
    @(negedge clk);
    chk("a_done_rst", 32'(bus.ppu_done_rst), 1);
    chk("a_fd_not_yet", 32'(bus.frame_done), 0);
    @(negedge clk);
    chk("a_frame_done", 32'(bus.frame_done), 1);
    chk("a_done_rst_1cyc", 32'(bus.ppu_done_rst), 0);
    @(negedge clk);
    chk("a_idle", 32'(bus.busy), 0);
    chk("a_fd_1cyc", 32'(bus.frame_done), 0);
    chk("a_sym_idx_last", 32'(bus.sym_idx), 4);
    chk("a_no_err", 32'({bus.err_underrun, bus.err_timeout}), 0);
    @(negedge clk);
    chk("a_di_vld_cycles", di_vld_cnt - b_di, FB);
    chk("a_strb_count", strb_cnt - b_strb, 5);
    chk("a_done_rst_count", done_rst_cnt - b_dr, 1);
    chk("a_frame_done_count", frame_done_cnt - b_fd, 1);
    chk("a_fd_after_rst", fd_cyc - dr_cyc, 1);

    // Underrun: encoder stalls after 4000 bits.
    do_start();
    b_dr = done_rst_cnt;
    load_bits(4000, -1);
    @(negedge clk);
    chk("u_err_underrun", 32'(bus.err_underrun), 1);
    chk("u_done_rst", 32'(bus.ppu_done_rst), 1);
    chk("u_rdy_low", 32'(bus.enc_rdy), 0);
    @(negedge clk);
    chk("u_frame_done", 32'(bus.frame_done), 1);
    @(negedge clk);
    chk("u_idle", 32'(bus.busy), 0);
    chk("u_err_sticky", 32'(bus.err_underrun), 1);
    chk("u_done_rst_count", done_rst_cnt - b_dr, 1);

    // Timeout: padding unit stops after 5000 bits; start also clears the underrun flag.
    do_start();
    chk("t_underrun_cleared", 32'(bus.err_underrun), 0);
    chk("t_enc_rdy", 32'(bus.enc_rdy), 1);
    b_strb = strb_cnt;
    load_bits(FB, -1);
    drain_bits(5000, 0, -1);
    repeat (TO - 1) @(negedge clk);
    chk("t_not_yet", 32'(bus.err_timeout), 0);
    chk("t_still_busy", 32'(bus.busy), 1);
    @(negedge clk);
    chk("t_err_timeout", 32'(bus.err_timeout), 1);
    chk("t_done_rst", 32'(bus.ppu_done_rst), 1);
    @(negedge clk);
    chk("t_frame_done", 32'(bus.frame_done), 1);
    @(negedge clk);
    chk("t_idle", 32'(bus.busy), 0);
    chk("t_err_sticky", 32'(bus.err_timeout), 1);
    chk("t_strb_count", strb_cnt - b_strb, 2);

    // Reset in the middle of DRAIN.
    do_start();
    chk("r_timeout_cleared", 32'(bus.err_timeout), 0);
    load_bits(FB, -1);
    drain_bits(5000, 0, -1);
    chk("r_sym_idx_pre", 32'(bus.sym_idx), 1);
    chk("r_busy_pre", 32'(bus.busy), 1);
    b_dr  = done_rst_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk("r_outputs_zero", outs(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("r_outputs_after", outs(), 0);
    chk("r_no_done_rst", done_rst_cnt - b_dr, 0);

    chk("di_sb_empty", di_q.size(), 0);
    chk("sym_sb_empty", idx_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
